clk_enable_sched: RTL and testbench

- Programmable clock-enable scheduler for the NES-to-VGA pipeline.
- Replaces the ad-hoc use of ripple-divided clocks: one fast clock drives all logic, and this block issues per-channel single-cycle enable ticks at configurable divide ratios (e.g. pixel, PPU-dot and audio strobes).
- A valid/ready config port reprograms channels at runtime. A new setting takes effect only at a channel wrap, so an in-progress period is never shortened or stretched.

---
 rtl/clk_enable_sched_if.sv | 15 +
 rtl/clk_enable_sched.sv | 113 +++++++++++
 tb/tb_clk_enable_sched.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/clk_enable_sched_if.sv
// Config request port for the clock-enable scheduler: one valid/ready request
// selects a channel and carries its new divisor and enable.
interface clk_enable_sched_if #(
  parameter int CHW = 2,
  parameter int W   = 8
);
  logic           cfg_valid;
  logic           cfg_ready;
  logic [CHW-1:0] cfg_ch;
  logic [W-1:0]   cfg_div;
  logic           cfg_en;

  modport master (output cfg_valid, cfg_ch, cfg_div, cfg_en, input  cfg_ready);
  modport slave  (input  cfg_valid, cfg_ch, cfg_div, cfg_en, output cfg_ready);
endinterface

// File: rtl/clk_enable_sched.sv
// Programmable clock-enable scheduler: one fast clock, per-channel single-cycle
// ticks at runtime-programmable divide ratios, reconfigured only at channel wrap.

module clk_enable_sched_ch #(
  parameter int W           = 8,
  parameter int DEFAULT_DIV = 4
) (
  input  logic         initialclk,
  input  logic         reset,
  input  logic         staged,
  input  logic [W-1:0] new_div,
  input  logic         new_en,
  output logic         tick,
  output logic         phase,
  output logic         apply_ok
);
  logic [W-1:0] div, cnt;
  logic         en;

  assign tick     = en && (cnt == div - W'(1));
  // A staged config may only land at a wrap or on an idle channel.
  assign apply_ok = !en || tick;

  always_ff @(posedge initialclk or posedge reset) begin
    if (reset) begin
      div   <= W'(DEFAULT_DIV);
      en    <= 1'b1;
      cnt   <= '0;
      phase <= 1'b0;
    end else if (staged && apply_ok) begin
      div   <= new_div;
      en    <= new_en;
      cnt   <= '0;
      phase <= new_en ? (phase ^ tick) : 1'b0;
    end else if (!en) begin
      cnt   <= '0;
      phase <= 1'b0;
    end else if (tick) begin
      cnt   <= '0;
      phase <= ~phase;
    end else begin
      cnt   <= cnt + W'(1);
    end
  end
endmodule

module clk_enable_sched #(
  parameter int NUM_CH      = 4,
  parameter int CHW         = 2,
  parameter int W           = 8,
  parameter int DEFAULT_DIV = 4
) (
  input  logic              initialclk,
  input  logic              reset,
  clk_enable_sched_if.slave cfg,
  output logic [NUM_CH-1:0] tick,
  output logic [NUM_CH-1:0] phase,
  output logic [NUM_CH-1:0] pending
);
  typedef struct packed {
    logic [CHW-1:0] ch;
    logic [W-1:0]   div;
    logic           en;
  } cfg_req_t;

  localparam logic [CHW:0] NCH = (CHW+1)'(NUM_CH);

  cfg_req_t          req, stg;
  logic              stg_valid;
  logic              accept, in_range, applied;
  logic [NUM_CH-1:0] apply_ok;

  assign cfg.cfg_ready = !stg_valid;
  assign accept        = cfg.cfg_valid && !stg_valid;
  assign in_range      = {1'b0, cfg.cfg_ch} < NCH;
  assign applied       = |(pending & apply_ok);

  always_comb begin
    req     = '0;
    req.ch  = cfg.cfg_ch;
    // Divisor 0 is meaningless; treat it as divide-by-one.
    req.div = (cfg.cfg_div == '0) ? W'(1) : cfg.cfg_div;
    req.en  = cfg.cfg_en;
  end

  always_ff @(posedge initialclk or posedge reset) begin
    if (reset) begin
      stg_valid <= 1'b0;
      stg       <= '0;
    end else if (accept) begin
      // Out-of-range channels complete the handshake but are dropped.
      stg_valid <= in_range;
      if (in_range) stg <= req;
    end else if (applied) begin
      stg_valid <= 1'b0;
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    assign pending[i] = stg_valid && (stg.ch == CHW'(i));

    clk_enable_sched_ch #(.W(W), .DEFAULT_DIV(DEFAULT_DIV)) u_ch (
      .initialclk (initialclk),
      .reset      (reset),
      .staged     (pending[i]),
      .new_div    (stg.div),
      .new_en     (stg.en),
      .tick       (tick[i]),
      .phase      (phase[i]),
      .apply_ok   (apply_ok[i])
    );
  end
endmodule

// File: tb/tb_clk_enable_sched.sv
// Directed bench for clk_enable_sched: default run, reprogramming, disable,
// back-to-back requests, out-of-range channel, reset while staged.
module tb_clk_enable_sched;
  logic       initialclk = 1'b0;
  logic       reset      = 1'b1;
  logic [3:0] tick, phase, pending;
  logic [2:0] tick3, phase3, pending3;
  int         cyc, n_chk, n_pass;

  clk_enable_sched_if #(.CHW(2), .W(8)) cfg  ();
  clk_enable_sched_if #(.CHW(2), .W(8)) cfg3 ();

  clk_enable_sched #(.NUM_CH(4), .CHW(2), .W(8), .DEFAULT_DIV(4)) u_dut (
    .initialclk (initialclk), .reset (reset), .cfg (cfg.slave),
    .tick (tick), .phase (phase), .pending (pending));

  clk_enable_sched #(.NUM_CH(3), .CHW(2), .W(8), .DEFAULT_DIV(4)) u_dut3 (
    .initialclk (initialclk), .reset (reset), .cfg (cfg3.slave),
    .tick (tick3), .phase (phase3), .pending (pending3));

  always #5 initialclk = ~initialclk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    else n_pass++;
  endtask

  task automatic step();
    @(posedge initialclk);
    @(negedge initialclk);
    cyc++;
  endtask

  task automatic drive(input logic v, input logic [1:0] ch, input logic [7:0] dv, input logic en);
    cfg.cfg_valid = v; cfg.cfg_ch = ch; cfg.cfg_div = dv; cfg.cfg_en = en;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    drive(1'b0, 2'd0, 8'd0, 1'b0);
    cfg3.cfg_valid = 1'b0; cfg3.cfg_ch = '0; cfg3.cfg_div = '0; cfg3.cfg_en = 1'b0;
    repeat (2) @(posedge initialclk);
    @(negedge initialclk);
    reset = 1'b0;
    cyc   = 0;
  endtask

  function automatic logic [3:0] def4(input int c);
    return (c % 4 == 3) ? 4'hF : 4'h0;
  endfunction

  function automatic logic [3:0] ph4(input int c);
    return ((c / 4) % 2 == 1) ? 4'hF : 4'h0;
  endfunction

  // Default divisor, free running.
  task automatic t_default();
    do_reset();
    chk("rst_ready", cfg.cfg_ready, 1);
    for (int c = 0; c < 20; c++) begin
      chk($sformatf("def_tick_c%0d", c), tick, def4(c));
      chk($sformatf("def_phase_c%0d", c), phase, ph4(c));
      chk($sformatf("def_pend_c%0d", c), pending, 0);
      chk($sformatf("def_ready_c%0d", c), cfg.cfg_ready, 1);
      step();
    end
  endtask

  // ch1 -> div 2, accepted mid-period, applied at its wrap.
  task automatic t_reprog();
    logic [3:0] e, p;
    do_reset();
    while (cyc < 5) step();
    drive(1'b1, 2'd1, 8'd2, 1'b1);
    chk("rp_ready_c5", cfg.cfg_ready, 1);
    step();
    drive(1'b0, 2'd0, 8'd0, 1'b0);
    chk("rp_pend_c6", pending, 4'b0010);
    chk("rp_ready_c6", cfg.cfg_ready, 0);
    step();
    chk("rp_pend_c7", pending, 4'b0010);
    chk("rp_tick_c7", tick, 4'hF);
    step();
    chk("rp_pend_c8", pending, 0);
    chk("rp_ready_c8", cfg.cfg_ready, 1);
    for (int c = 8; c < 16; c++) begin
      e = def4(c); e[1] = (c % 2 == 1);
      p = ph4(c);  p[1] = (((c - 8) / 2) % 2 == 1);
      chk($sformatf("rp_tick_c%0d", c), tick, e);
      chk($sformatf("rp_phase_c%0d", c), phase, p);
      step();
    end
  endtask

  // ch2 disabled, then re-enabled with div 0 (runs at div 1).
  task automatic t_disable();
    logic [3:0] e, p;
    do_reset();
    drive(1'b1, 2'd2, 8'd4, 1'b0);
    step();
    drive(1'b0, 2'd0, 8'd0, 1'b0);
    chk("ds_pend_c1", pending, 4'b0100);
    step(); step();
    chk("ds_tick_c3", tick, 4'hF);
    chk("ds_pend_c3", pending, 4'b0100);
    step();
    chk("ds_pend_c4", pending, 0);
    chk("ds_tick_c4", tick, 0);
    chk("ds_phase_c4", phase, 4'b1011);
    drive(1'b1, 2'd2, 8'd0, 1'b1);
    step();
    drive(1'b0, 2'd0, 8'd0, 1'b0);
    chk("ds_pend_c5", pending, 4'b0100);
    chk("ds_tick_c5", tick, 0);
    chk("ds_phase_c5", phase, 4'b1011);
    step();
    chk("ds_pend_c6", pending, 0);
    for (int c = 6; c < 12; c++) begin
      e = def4(c) | 4'b0100;
      p = ph4(c); p[2] = ((c - 6) % 2 == 1);
      chk($sformatf("ds_tick_c%0d", c), tick, e);
      chk($sformatf("ds_phase_c%0d", c), phase, p);
      step();
    end
  endtask

  // Held valid across two requests: ch0 div 6 then ch3 div 3.
  task automatic t_b2b();
    logic [3:0] e;
    do_reset();
    drive(1'b1, 2'd0, 8'd6, 1'b1);
    step();
    chk("bb_ready_c1", cfg.cfg_ready, 0);
    chk("bb_pend_c1", pending, 4'b0001);
    drive(1'b1, 2'd3, 8'd3, 1'b1);
    step();
    chk("bb_ready_c2", cfg.cfg_ready, 0);
    step();
    chk("bb_pend_c3", pending, 4'b0001);
    chk("bb_tick_c3", tick, 4'hF);
    step();
    chk("bb_ready_c4", cfg.cfg_ready, 1);
    chk("bb_pend_c4", pending, 0);
    step();
    drive(1'b0, 2'd0, 8'd0, 1'b0);
    chk("bb_pend_c5", pending, 4'b1000);
    chk("bb_ready_c5", cfg.cfg_ready, 0);
    step(); step();
    chk("bb_pend_c7", pending, 4'b1000);
    chk("bb_tick_c7", tick, 4'b1110);
    step();
    for (int c = 8; c < 20; c++) begin
      e = def4(c);
      e[0] = ((c - 4) % 6 == 5);
      e[3] = ((c - 8) % 3 == 2);
      chk($sformatf("bb_tick_c%0d", c), tick, e);
      chk($sformatf("bb_pend_c%0d", c), pending, 0);
      step();
    end
  endtask

  // Channel 3 on a three-channel instance: handshake completes, nothing changes.
  task automatic t_range();
    do_reset();
    step();
    cfg3.cfg_valid = 1'b1; cfg3.cfg_ch = 2'd3; cfg3.cfg_div = 8'd7; cfg3.cfg_en = 1'b0;
    chk("or_ready_c1", cfg3.cfg_ready, 1);
    step();
    cfg3.cfg_valid = 1'b0;
    for (int c = 2; c < 10; c++) begin
      chk($sformatf("or_ready_c%0d", c), cfg3.cfg_ready, 1);
      chk($sformatf("or_pend_c%0d", c), pending3, 0);
      chk($sformatf("or_tick_c%0d", c), tick3, (c % 4 == 3) ? 3'h7 : 3'h0);
      chk($sformatf("or_phase_c%0d", c), phase3, ((c / 4) % 2 == 1) ? 3'h7 : 3'h0);
      step();
    end
  endtask

  // Reset while a ch0 config is staged.
  task automatic t_rst_staged();
    do_reset();
    while (cyc < 4) step();
    drive(1'b1, 2'd0, 8'd2, 1'b1);
    step();
    drive(1'b0, 2'd0, 8'd0, 1'b0);
    step(); step();
    chk("rs_pend_c7", pending, 4'b0001);
    chk("rs_tick_c7", tick, 4'hF);
    chk("rs_phase_c7", phase, 4'hF);
    #2 reset = 1'b1;
    #1;
    chk("rs_tick_async", tick, 0);
    chk("rs_phase_async", phase, 0);
    chk("rs_pend_async", pending, 0);
    chk("rs_ready_async", cfg.cfg_ready, 1);
    @(posedge initialclk);
    @(negedge initialclk);
    reset = 1'b0;
    cyc   = 0;
    for (int c = 0; c < 9; c++) begin
      chk($sformatf("rs_tick_c%0d", c), tick, def4(c));
      chk($sformatf("rs_pend_c%0d", c), pending, 0);
      step();
    end
  endtask

  initial begin
    n_chk = 0; n_pass = 0; cyc = 0;
    t_default();
    t_reprog();
    t_disable();
    t_b2b();
    t_range();
    t_rst_staged();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
